// File: rtl/matrix_pkg.sv
// ============================================================================
// Module      : matrix_pkg
// Description : Shared defaults, loader state encoding and width helpers for
//               the matrix loader and its register banks.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package matrix_pkg;

    localparam int c_DEF_DATA_W = 8;
    localparam int c_DEF_N      = 4;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        FULL   = 2'd2
    } loaderState_t;

    // Element counter must hold 2*N*N without wrapping.
    function automatic int countWidth(input int n);
        return $clog2(2 * n * n) + 1;
    endfunction

    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/matrix_reg_bank.sv
// ============================================================================
// Module      : matrix_reg_bank
// Description : N x N element register array written one cell at a time by
//               row/col index; all cells cleared by asynchronous reset.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module matrix_reg_bank
    import matrix_pkg::*;
#(
    parameter int DATA_W = c_DEF_DATA_W,
    parameter int N      = c_DEF_N,
    parameter int IDX_W  = idxWidth(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [IDX_W-1:0]  row,
    input  logic [IDX_W-1:0]  col,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] mat [0:N-1][0:N-1]
);

    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            logic [DATA_W-1:0] r_cell;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cell <= '0;
                end else if (we && (row == IDX_W'(r)) && (col == IDX_W'(c))) begin
                    r_cell <= wdata;
                end
            end

            assign mat[r][c] = r_cell;
        end
    end

endmodule

`default_nettype wire

// File: rtl/matrix_loader.sv
// ============================================================================
// Module      : matrix_loader
// Description : Streams 2*N*N elements into matrices A then B (row-major) and
//               holds them for a downstream multiplier until acknowledged.
//               Define MATRIX_LOADER_COLMAJOR_B_EN to load B column-major.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module matrix_loader
    import matrix_pkg::*;
#(
    parameter int DATA_W = c_DEF_DATA_W,
    parameter int N      = c_DEF_N
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_data,
    input  logic                        flush,
    output logic [DATA_W-1:0]           mat_a [0:N-1][0:N-1],
    output logic [DATA_W-1:0]           mat_b [0:N-1][0:N-1],
    output logic                        mats_valid,
    input  logic                        mats_ack,
    output logic [countWidth(N)-1:0]    elem_count
);

    localparam int c_CNT_W = countWidth(N);
    localparam int c_IDX_W = idxWidth(N);
    localparam logic [c_CNT_W-1:0] c_LAST_A = c_CNT_W'(N * N - 1);
    localparam logic [c_CNT_W-1:0] c_LAST_B = c_CNT_W'(2 * N * N - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_MAX = c_IDX_W'(N - 1);

    loaderState_t         r_state;
    loaderState_t         w_nextState;
    logic [c_CNT_W-1:0]   r_elemCount;
    logic [c_IDX_W-1:0]   r_row;
    logic [c_IDX_W-1:0]   r_col;
    logic                 w_transfer;
    logic                 w_restart;
    logic                 w_weA;
    logic                 w_weB;
    logic [c_IDX_W-1:0]   w_rowB;
    logic [c_IDX_W-1:0]   w_colB;

    // A flushed beat is never accepted, so it can neither be written nor counted.
    assign w_transfer = in_valid && in_ready && !flush;
    assign w_restart  = flush || ((r_state == FULL) && mats_ack);
    assign w_weA      = w_transfer && (r_state == LOAD_A);
    assign w_weB      = w_transfer && (r_state == LOAD_B);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= LOAD_A;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        if (flush) begin
            w_nextState = LOAD_A;
        end else begin
            case (r_state)
                LOAD_A:  if (w_transfer && (r_elemCount == c_LAST_A)) w_nextState = LOAD_B;
                LOAD_B:  if (w_transfer && (r_elemCount == c_LAST_B)) w_nextState = FULL;
                FULL:    if (mats_ack) w_nextState = LOAD_A;
                default: w_nextState = LOAD_A;
            endcase
        end
    end

    // Handshake outputs depend on state alone, keeping in_valid off any comb path.
    always_comb begin
        in_ready   = 1'b1;
        mats_valid = 1'b0;
        if (r_state == FULL) begin
            in_ready   = 1'b0;
            mats_valid = 1'b1;
        end
    end

    // Row/col walk each matrix in row-major order and wrap at the A/B boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_elemCount <= '0;
            r_row       <= '0;
            r_col       <= '0;
        end else if (w_restart) begin
            r_elemCount <= '0;
            r_row       <= '0;
            r_col       <= '0;
        end else if (w_transfer) begin
            r_elemCount <= r_elemCount + c_CNT_W'(1);
            if (r_col == c_IDX_MAX) begin
                r_col <= '0;
                r_row <= (r_row == c_IDX_MAX) ? '0 : r_row + c_IDX_W'(1);
            end else begin
                r_col <= r_col + c_IDX_W'(1);
            end
        end
    end

    assign elem_count = r_elemCount;

`ifdef MATRIX_LOADER_COLMAJOR_B_EN
    assign w_rowB = r_col;
    assign w_colB = r_row;
`else
    assign w_rowB = r_row;
    assign w_colB = r_col;
`endif

    matrix_reg_bank #(
        .DATA_W (DATA_W),
        .N      (N),
        .IDX_W  (c_IDX_W)
    ) u_bankA (
        .clk   (clk),
        .rst   (rst),
        .we    (w_weA),
        .row   (r_row),
        .col   (r_col),
        .wdata (in_data),
        .mat   (mat_a)
    );

    matrix_reg_bank #(
        .DATA_W (DATA_W),
        .N      (N),
        .IDX_W  (c_IDX_W)
    ) u_bankB (
        .clk   (clk),
        .rst   (rst),
        .we    (w_weB),
        .row   (w_rowB),
        .col   (w_colB),
        .wdata (in_data),
        .mat   (mat_b)
    );

endmodule

`default_nettype wire

// File: tb/tb_matrix_loader.sv
// ============================================================================
// Module      : tb_matrix_loader
// Description : Scoreboard bench for matrix_loader with a reference model of
//               element placement; honours MATRIX_LOADER_COLMAJOR_B_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_matrix_loader;

    localparam int DATA_W = 8;
    localparam int N      = 4;
    localparam int NN     = N * N;
    localparam int CW     = $clog2(2 * NN) + 1;
    localparam int PW     = 2 * NN * DATA_W;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              flush = 1'b0;
    logic              mats_ack = 1'b0;
    logic [DATA_W-1:0] mat_a [0:N-1][0:N-1];
    logic [DATA_W-1:0] mat_b [0:N-1][0:N-1];
    logic              mats_valid;
    logic [CW-1:0]     elem_count;

    int checks = 0;
    int errors = 0;

    // Reference model: element store indexed row*N+col, and count of accepted beats.
    logic [DATA_W-1:0] mA [NN];
    logic [DATA_W-1:0] mB [NN];
    int                cnt = 0;
    logic [PW-1:0]     expQ [$];
    bit                prevValid = 1'b0;

    matrix_loader #(.DATA_W(DATA_W), .N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .flush      (flush),
        .mat_a      (mat_a),
        .mat_b      (mat_b),
        .mats_valid (mats_valid),
        .mats_ack   (mats_ack),
        .elem_count (elem_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] snapshot();
        logic [PW-1:0] v;
        for (int e = 0; e < NN; e++) begin
            v[e*DATA_W +: DATA_W]        = mA[e];
            v[(NN+e)*DATA_W +: DATA_W]   = mB[e];
        end
        return v;
    endfunction

    task automatic modelReset();
        for (int e = 0; e < NN; e++) begin
            mA[e] = '0;
            mB[e] = '0;
        end
        cnt = 0;
        expQ.delete();
    endtask

    task automatic checkMats(input string tag);
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                chk($sformatf("%s_a[%0d][%0d]", tag, r, c), int'(mat_a[r][c]), int'(mA[r*N+c]));
                chk($sformatf("%s_b[%0d][%0d]", tag, r, c), int'(mat_b[r][c]), int'(mB[r*N+c]));
            end
        end
    endtask

    // One clock: apply inputs, advance the model by the handshake rules, check status.
    task automatic cycle(input bit v, input logic [DATA_W-1:0] d, input bit f, input bit ack);
        int k;
        in_valid = v;
        in_data  = d;
        flush    = f;
        mats_ack = ack;
        @(posedge clk);
        if (f) begin
            cnt = 0;
        end else if (cnt == 2 * NN) begin
            if (ack) cnt = 0;
        end else if (v) begin
            if (cnt < NN) begin
                mA[cnt] = d;
            end else begin
                k = cnt - NN;
`ifdef MATRIX_LOADER_COLMAJOR_B_EN
                mB[(k % N) * N + (k / N)] = d;
`else
                mB[k] = d;
`endif
            end
            cnt++;
            if (cnt == 2 * NN) expQ.push_back(snapshot());
        end
        #1;
        chk("elem_count", int'(elem_count), cnt);
        chk("in_ready", int'(in_ready), int'(cnt != 2 * NN));
        chk("mats_valid", int'(mats_valid), int'(cnt == 2 * NN));
    endtask

    // Monitor: every rising mats_valid must match the oldest predicted matrix pair.
    initial begin : monitor
        logic [PW-1:0] exp;
        forever begin
            @(negedge clk);
            if (mats_valid && !prevValid) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mon_unexpected actual=mats_valid required=no_output at %0t", $time);
                end else begin
                    exp = expQ.pop_front();
                    for (int e = 0; e < NN; e++) begin
                        chk($sformatf("mon_a[%0d]", e), int'(mat_a[e/N][e%N]), int'(exp[e*DATA_W +: DATA_W]));
                        chk($sformatf("mon_b[%0d]", e), int'(mat_b[e/N][e%N]), int'(exp[(NN+e)*DATA_W +: DATA_W]));
                    end
`ifdef MATRIX_LOADER_COLMAJOR_B_EN
                    for (int i = 0; i < N; i++) begin
                        for (int j = 0; j < N; j++) begin
                            int cDut = 0;
                            int cRef = 0;
                            for (int m = 0; m < N; m++) begin
                                cDut += int'(mat_a[i][m]) * int'(mat_b[m][j]);
                                cRef += int'(exp[(i*N+m)*DATA_W +: DATA_W]) *
                                        int'(exp[(NN+m*N+j)*DATA_W +: DATA_W]);
                            end
                            chk($sformatf("mon_c[%0d][%0d]", i, j), cDut, cRef);
                        end
                    end
`endif
                end
            end
            prevValid = mats_valid;
        end
    end

    initial begin
        int guard;
        int k;
        bit v;
        modelReset();
        #1 rst = 1'b1;
        #11;
        chk("rst_elem_count", int'(elem_count), 0);
        chk("rst_mats_valid", int'(mats_valid), 0);
        checkMats("rst");
        #1 rst = 1'b0;
        #1 chk("rst_in_ready", int'(in_ready), 1);

        // Gapless stream 1..32.
        for (int i = 1; i <= 2 * NN; i++) cycle(1'b1, DATA_W'(i), 1'b0, 1'b0);
        chk("seq_a00", int'(mat_a[0][0]), 1);
        chk("seq_a33", int'(mat_a[3][3]), 16);
`ifdef MATRIX_LOADER_COLMAJOR_B_EN
        chk("seq_b10", int'(mat_b[1][0]), 18);
        chk("seq_b01", int'(mat_b[0][1]), 21);
`else
        chk("seq_b01", int'(mat_b[0][1]), 18);
`endif

        // FULL ignores in_valid while unacknowledged, then ack returns to LOAD_A.
        for (int i = 0; i < 5; i++) cycle(i[0], DATA_W'($urandom_range(0, 255)), 1'b0, 1'b0);
        checkMats("hold");
        cycle(1'b0, '0, 1'b0, 1'b1);

        // Same 1..32 with random gaps.
        k = 1;
        guard = 0;
        while (k <= 2 * NN && guard < 400) begin
            v = 1'($urandom_range(0, 1));
            cycle(v, DATA_W'(k), 1'b0, 1'b0);
            if (v) k++;
            guard++;
        end
        chk("gap_count", int'(elem_count), 2 * NN);
        chk("gap_a33", int'(mat_a[3][3]), 16);
        cycle(1'b0, '0, 1'b0, 1'b1);

        // Flush after 20 transfers coinciding with a valid beat.
        for (int i = 1; i <= 20; i++) cycle(1'b1, DATA_W'(i), 1'b0, 1'b0);
        cycle(1'b1, DATA_W'(99), 1'b1, 1'b0);
        chk("flush_a00", int'(mat_a[0][0]), 1);
        checkMats("flush");

        // Randomised traffic including flush/ack collisions in FULL.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 9) < 7), DATA_W'($urandom_range(0, 255)),
                  ($urandom_range(0, 29) == 0), ($urandom_range(0, 2) == 0));
        end
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Async reset mid-cycle during LOAD_B.
        for (int i = 0; i < NN + 4; i++) cycle(1'b1, DATA_W'($urandom_range(1, 255)), 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        modelReset();
        chk("arst_elem_count", int'(elem_count), 0);
        chk("arst_mats_valid", int'(mats_valid), 0);
        checkMats("arst");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b0);

        chk("expQ_drained", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/matrix_loader.md
MATRIX_LOADER -- requirements
Module: matrix_loader

Interface
REQ-001 The module SHALL have parameter DATA_W, default 8, giving the element width in bits.
REQ-002 The module SHALL have parameter N, default 4, giving the matrix dimension (N x N).
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port in_valid, input, 1 bit: the upstream element on in_data is valid.
REQ-006 Port in_ready, output, 1 bit: the loader can accept an element this cycle.
REQ-007 Port in_data, input, DATA_W bits: the streamed element value.
REQ-008 Port flush, input, 1 bit: abandon the current load and restart at element 0.
REQ-009 Port mat_a, output, unpacked array [0:N-1][0:N-1] of DATA_W bits: the assembled matrix A.
REQ-010 Port mat_b, output, unpacked array [0:N-1][0:N-1] of DATA_W bits: the assembled matrix B.
REQ-011 Port mats_valid, output, 1 bit: mat_a and mat_b are complete and stable.
REQ-012 Port mats_ack, input, 1 bit: the downstream multiplier has consumed the matrices.
REQ-013 Port elem_count, output, clog2(2*N*N)+1 bits: the number of elements accepted in the current load.

Function
REQ-014 The FSM SHALL have exactly three states: LOAD_A, LOAD_B and FULL.
REQ-015 in_ready SHALL equal (state != FULL) and SHALL be decoded from state only (no combinational path from in_valid).
REQ-016 A transfer SHALL occur on a rising edge when in_valid && in_ready are both high.
REQ-017 In LOAD_A, transfer k (k = 0..N*N-1) SHALL write mat_a[k/N][k%N].
REQ-018 After N*N transfers, the state SHALL go to LOAD_B.
REQ-019 In LOAD_B, transfer k (k = 0..N*N-1) SHALL write mat_b[k/N][k%N], i.e. row-major order.
REQ-020 After the final B transfer, the state SHALL go to FULL and mats_valid SHALL rise on the same edge.
REQ-021 In FULL, mat_a and mat_b SHALL hold unchanged and in_valid SHALL be ignored.
REQ-022 When mats_ack is high in FULL, the next state SHALL be LOAD_A, elem_count SHALL be 0 and mats_valid SHALL be 0.
REQ-023 When in LOAD_A or LOAD_B, mats_ack SHALL be ignored.
REQ-024 elem_count SHALL increment by 1 per transfer, reach 2*N*N in FULL, and never wrap.
REQ-025 When flush is high, on the next edge the state SHALL be LOAD_A, elem_count SHALL be 0 and mats_valid SHALL be 0; matrix contents SHALL be retained.
REQ-026 flush SHALL take priority over a simultaneous transfer, and that transfer SHALL NOT be written.
REQ-027 flush SHALL take priority over a simultaneous mats_ack; both produce the same result.
REQ-028 Latency SHALL be 1 cycle: the final transfer edge is the edge on which mats_valid rises.
REQ-029 Minimum throughput SHALL be one element per cycle while loading.
REQ-030 Minimum turnaround SHALL be 1 idle cycle (in_ready low) per matrix pair.

Reset
REQ-031 When rst is high, the state SHALL be LOAD_A, elem_count SHALL be 0, mats_valid SHALL be 0, every mat_a and mat_b element SHALL be 0, and in_ready SHALL be 1 once rst deasserts.
REQ-032 An rst asserted mid-load or in FULL SHALL discard all progress immediately, without waiting for a clock edge.

Configuration
REQ-033 With macro MATRIX_LOADER_COLMAJOR_B_EN defined, LOAD_B transfer k SHALL write mat_b[k%N][k/N] (column-major); matrix A SHALL be unaffected.
REQ-034 With MATRIX_LOADER_COLMAJOR_B_EN undefined, matrix B SHALL be loaded row-major per REQ-019.

Structure
REQ-035 Shared package matrix_pkg SHALL hold DATA_W and N defaults, the loader state enum (LOAD_A, LOAD_B, FULL) and the count-width constant.
REQ-036 Sub-module matrix_reg_bank (N x N register array with write-enable and row/col index) SHALL be instantiated twice, once for A and once for B.
REQ-037 The matrix outputs SHALL connect directly to the existing combinational 4x4 multiplier inputs.

Verification
REQ-038 Reset then stream 32 values 1..32 with in_valid held high -> mats_valid rises after the 32nd edge, mat_a[0][0]=1, mat_a[3][3]=16, mat_b[0][1]=18, elem_count=32, in_ready=0.
REQ-039 In FULL, hold mats_ack=0 for 5 cycles while toggling in_valid -> outputs unchanged; then pulse mats_ack -> LOAD_A, elem_count=0, in_ready=1 next cycle.
REQ-040 Random in_valid gaps (50%) while loading 32 elements -> contents identical to the gapless case; elem_count increments only on transfers.
REQ-041 flush asserted after 20 transfers, coinciding with a valid element -> elem_count=0, state LOAD_A, mat_a[0][0] still 1, flushed element not written.
REQ-042 Assert rst asynchronously mid-cycle during LOAD_B -> all outputs zero before the next edge.
REQ-043 With MATRIX_LOADER_COLMAJOR_B_EN defined, stream 1..32 -> mat_b[1][0]=18 and mat_b[0][1]=21; connect the multiplier and check C against a reference model.
